// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word/index widths, round constants K[0..63],
// the message-schedule sigma functions and the schedule FSM state encoding.
package sha256_pkg;

    localparam int unsigned WORD_WIDTH   = 32;
    localparam int unsigned NUMBER_OF_KS = 64;
    localparam int unsigned INDEX_WIDTH  = 6;
    localparam int unsigned WINDOW_DEPTH = 16;
    localparam int unsigned BLOCK_WIDTH  = WORD_WIDTH * WINDOW_DEPTH;

    typedef logic [WORD_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam word_t K_TABLE [NUMBER_OF_KS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
    function automatic word_t sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
    function automatic word_t sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational round-constant lookup: 6-bit round index to K[index].
import sha256_pkg::*;

module sha256_k_rom (
    input  logic [INDEX_WIDTH-1:0] index,
    output logic [WORD_WIDTH-1:0]  k_c
);

    // Constant table read, folds to logic at synthesis
    always_comb begin
        k_c = K_TABLE[index];
    end

endmodule

// File: rtl/sha256_message_schedule.sv
// SHA-256 message schedule: expands a 512-bit block into W[0..63] through a
// 16-word sliding window, one word per valid/ready handshake.
// Optional macro SHA256_MSG_SCHED_K_EN adds the k_word output (K[t] aligned
// with w_word) backed by sha256_k_rom.
import sha256_pkg::*;

module sha256_message_schedule (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [BLOCK_WIDTH-1:0] block,
    input  logic                   w_ready,
    output logic                   busy,
    output logic                   w_valid,
    output logic [WORD_WIDTH-1:0]  w_word,
    output logic [INDEX_WIDTH-1:0] w_index,
    output logic                   done
`ifdef SHA256_MSG_SCHED_K_EN
    ,
    output logic [WORD_WIDTH-1:0]  k_word
`endif
);

    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUMBER_OF_KS - 1);

    state_t                 state;
    logic [INDEX_WIDTH-1:0] t;
    word_t                  window [WINDOW_DEPTH];
    word_t                  next_word_c;

    // W[t+16] from the current window; carries past bit 31 drop naturally
    always_comb begin
        next_word_c = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0];
    end

    // Schedule FSM, round counter and sliding window
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            t     <= '0;
            for (int i = 0; i < int'(WINDOW_DEPTH); i++) begin
                window[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < int'(WINDOW_DEPTH); i++) begin
                            window[i] <= block[(int'(WINDOW_DEPTH) - 1 - i) * int'(WORD_WIDTH) +: WORD_WIDTH];
                        end
                        t     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (w_ready) begin
                        // Last word: hold the window so W64+ is never exposed
                        if (t == LAST_INDEX) begin
                            state <= DONE;
                        end else begin
                            for (int i = 0; i < int'(WINDOW_DEPTH) - 1; i++) begin
                                window[i] <= window[i+1];
                            end
                            window[WINDOW_DEPTH-1] <= next_word_c;
                            t <= t + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registered state; w_ready never reaches them
    assign busy    = (state != IDLE);
    assign w_valid = (state == RUN);
    assign done    = (state == DONE);
    assign w_word  = window[0];
    assign w_index = t;

`ifdef SHA256_MSG_SCHED_K_EN
    logic [WORD_WIDTH-1:0] k_rom_c;

    sha256_k_rom u_k_rom (
        .index (t),
        .k_c   (k_rom_c)
    );

    // K is only meaningful alongside a valid word
    assign k_word = w_valid ? k_rom_c : '0;
`endif

endmodule

// File: tb/tb_sha256_message_schedule.sv
// Directed bench for sha256_message_schedule; also covers k_word when built
// with SHA256_MSG_SCHED_K_EN.
module tb_sha256_message_schedule;

    typedef logic [63:0][31:0] sched_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [511:0] block;
    logic         w_ready;
    logic         busy;
    logic         w_valid;
    logic [31:0]  w_word;
    logic [5:0]   w_index;
    logic         done;
`ifdef SHA256_MSG_SCHED_K_EN
    logic [31:0]  k_word;
`endif

    int errors = 0;
    int checks = 0;

    logic [511:0] abc_block;
    logic [511:0] alt_block;
    sched_t       exp_abc;
    sched_t       exp_alt;

    logic [31:0]  k_first;
    logic [31:0]  k_last;
    int           k_bad;

    sha256_message_schedule dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .block   (block),
        .w_ready (w_ready),
        .busy    (busy),
        .w_valid (w_valid),
        .w_word  (w_word),
        .w_index (w_index),
        .done    (done)
`ifdef SHA256_MSG_SCHED_K_EN
        ,
        .k_word  (k_word)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Full 64-entry schedule, computed on the whole array
    function automatic sched_t expand(input logic [511:0] b);
        sched_t w;
        for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) w[i] = ref_s1(w[i-2]) + w[i-7] + ref_s0(w[i-15]) + w[i-16];
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs from the first cycle after a start edge until done is seen (or a budget).
    // Collects accepted words, counts index errors and stall-hold violations.
    task automatic drain(input bit rnd, input int pulse_at, output sched_t got, output int n,
                         output int cyc, output int stall_bad, output int idx_bad, output bit saw_done);
        logic [31:0] pw;
        logic [5:0]  pi;
        bit          held;
        got = '0; n = 0; cyc = 1; stall_bad = 0; idx_bad = 0; saw_done = 0; held = 0;
        pw = '0; pi = '0;
        k_first = '0; k_last = '0; k_bad = 0;
        while (cyc < 2000) begin
            if (held && (w_word !== pw || w_index !== pi || w_valid !== 1'b1)) stall_bad++;
`ifdef SHA256_MSG_SCHED_K_EN
            if (w_valid && w_index == 6'd0) k_first = k_word;
            if (w_valid && w_index == 6'd63) k_last = k_word;
            if (!w_valid && k_word !== 32'h0) k_bad++;
`endif
            if (done) begin
                saw_done = 1;
                break;
            end
            held = 0;
            if (w_valid && int'(w_index) == pulse_at) begin
                start = 1'b1;
                block = alt_block;
            end else begin
                start = 1'b0;
            end
            if (w_valid) begin
                if (int'(w_index) != n) idx_bad++;
                w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (w_ready) begin
                    if (n < 64) got[n] = w_word;
                    n++;
                end else begin
                    held = 1; pw = w_word; pi = w_index;
                end
            end
            tick();
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; w_ready = 1'b0; block = '0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL reset_w_valid: got %b expected 0", w_valid); end
        checks++; if (w_word !== 32'h0) begin errors++; $display("FAIL reset_w_word: got %h expected 0", w_word); end
        checks++; if (w_index !== 6'd0) begin errors++; $display("FAIL reset_w_index: got %0d expected 0", w_index); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
`ifdef SHA256_MSG_SCHED_K_EN
        checks++; if (k_word !== 32'h0) begin errors++; $display("FAIL reset_k_word: got %h expected 0", k_word); end
`endif
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_start: busy %b expected 0", busy); end
    endtask

    task automatic test_abc();
        sched_t got; int n, cyc, sb, ib; bit sd;
        block = abc_block; start = 1'b1; w_ready = 1'b1;
        tick();
        start = 1'b0; block = '0;
        drain(1'b0, -1, got, n, cyc, sb, ib, sd);
        checks++; if (!sd) begin errors++; $display("FAIL abc_done_seen: got 0 expected 1"); end
        checks++; if (cyc != 65) begin errors++; $display("FAIL abc_done_latency: got %0d expected 65", cyc); end
        checks++; if (n != 64) begin errors++; $display("FAIL abc_word_count: got %0d expected 64", n); end
        checks++; if (ib != 0) begin errors++; $display("FAIL abc_index: got %0d errors expected 0", ib); end
        checks++; if (got[0] !== 32'h61626380) begin errors++; $display("FAIL abc_w0: got %h expected 61626380", got[0]); end
        checks++; if (got[15] !== 32'h00000018) begin errors++; $display("FAIL abc_w15: got %h expected 00000018", got[15]); end
        checks++; if (got[16] !== 32'h61626380) begin errors++; $display("FAIL abc_w16: got %h expected 61626380", got[16]); end
        checks++; if (got[17] !== 32'h000F0000) begin errors++; $display("FAIL abc_w17: got %h expected 000f0000", got[17]); end
        checks++; if (got[18] !== 32'h7DA86405) begin errors++; $display("FAIL abc_w18: got %h expected 7da86405", got[18]); end
        checks++; if (got[63] !== 32'h12B1EDEB) begin errors++; $display("FAIL abc_w63: got %h expected 12b1edeb", got[63]); end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (got[i] !== exp_abc[i]) begin errors++; $display("FAIL abc_seq[%0d]: got %h expected %h", i, got[i], exp_abc[i]); end
        end
`ifdef SHA256_MSG_SCHED_K_EN
        checks++; if (k_first !== 32'h428A2F98) begin errors++; $display("FAIL k_t0: got %h expected 428a2f98", k_first); end
        checks++; if (k_last !== 32'hC67178F2) begin errors++; $display("FAIL k_t63: got %h expected c67178f2", k_last); end
        checks++; if (k_bad != 0) begin errors++; $display("FAIL k_idle_zero: got %0d nonzero cycles expected 0", k_bad); end
`endif
        checks++; if (w_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL abc_done_cycle: w_valid %b busy %b expected 0 1", w_valid, busy); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abc_after_done: done %b busy %b expected 0 0", done, busy); end
    endtask

    task automatic test_stall();
        sched_t got; int n, cyc, sb, ib; bit sd;
        block = abc_block; start = 1'b1; w_ready = 1'b0;
        tick();
        start = 1'b0;
        drain(1'b1, -1, got, n, cyc, sb, ib, sd);
        checks++; if (!sd) begin errors++; $display("FAIL stall_done_seen: got 0 expected 1"); end
        checks++; if (n != 64) begin errors++; $display("FAIL stall_word_count: got %0d expected 64", n); end
        checks++; if (sb != 0) begin errors++; $display("FAIL stall_hold: got %0d violations expected 0", sb); end
        checks++; if (ib != 0) begin errors++; $display("FAIL stall_index: got %0d errors expected 0", ib); end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (got[i] !== exp_abc[i]) begin errors++; $display("FAIL stall_seq[%0d]: got %h expected %h", i, got[i], exp_abc[i]); end
        end
        tick();
    endtask

    task automatic test_start_ignored();
        sched_t got; int n, cyc, sb, ib; bit sd;
        block = abc_block; start = 1'b1; w_ready = 1'b1;
        tick();
        start = 1'b0;
        drain(1'b0, 10, got, n, cyc, sb, ib, sd);
        checks++; if (n != 64 || cyc != 65) begin errors++; $display("FAIL ignore_count: got %0d words at %0d expected 64 at 65", n, cyc); end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (got[i] !== exp_abc[i]) begin errors++; $display("FAIL ignore_seq[%0d]: got %h expected %h", i, got[i], exp_abc[i]); end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        sched_t got; int n, cyc, sb, ib; bit found;
        bit sd;
        block = alt_block; start = 1'b1; w_ready = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 100; c++) begin
            if (w_valid && w_index == 6'd30) begin found = 1; break; end
            tick();
        end
        checks++; if (!found) begin errors++; $display("FAIL rst_reach_t30: got 0 expected 1"); end
        reset = 1'b1; start = 1'b1; block = abc_block;
        tick();
        checks++; if (busy !== 1'b0 || w_valid !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_mid_ctrl: busy %b w_valid %b done %b expected 0 0 0", busy, w_valid, done); end
        checks++; if (w_word !== 32'h0 || w_index !== 6'd0) begin
            errors++; $display("FAIL rst_mid_data: w_word %h w_index %0d expected 0 0", w_word, w_index); end
`ifdef SHA256_MSG_SCHED_K_EN
        checks++; if (k_word !== 32'h0) begin errors++; $display("FAIL rst_mid_k: got %h expected 0", k_word); end
`endif
        reset = 1'b0;
        tick();
        start = 1'b0;
        drain(1'b0, -1, got, n, cyc, sb, ib, sd);
        checks++; if (n != 64 || cyc != 65) begin errors++; $display("FAIL rst_restart_count: got %0d words at %0d expected 64 at 65", n, cyc); end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (got[i] !== exp_abc[i]) begin errors++; $display("FAIL rst_restart_seq[%0d]: got %h expected %h", i, got[i], exp_abc[i]); end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        sched_t got; int n, cyc, sb, ib; bit sd;
        block = abc_block; start = 1'b1; w_ready = 1'b1;
        tick();
        start = 1'b0;
        drain(1'b0, -1, got, n, cyc, sb, ib, sd);
        checks++; if (!sd || n != 64) begin errors++; $display("FAIL b2b_first: done %b words %0d expected 1 64", sd, n); end
        start = 1'b1; block = alt_block;
        tick();
        checks++; if (busy !== 1'b0 || w_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_start_in_done: busy %b w_valid %b expected 0 0", busy, w_valid); end
        tick();
        start = 1'b0;
        checks++; if (w_valid !== 1'b1 || w_index !== 6'd0 || w_word !== exp_alt[0]) begin
            errors++; $display("FAIL b2b_second_w0: valid %b idx %0d word %h expected 1 0 %h", w_valid, w_index, w_word, exp_alt[0]); end
        drain(1'b0, -1, got, n, cyc, sb, ib, sd);
        checks++; if (n != 64 || cyc != 65) begin errors++; $display("FAIL b2b_second_count: got %0d words at %0d expected 64 at 65", n, cyc); end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (got[i] !== exp_alt[i]) begin errors++; $display("FAIL b2b_seq[%0d]: got %h expected %h", i, got[i], exp_alt[i]); end
        end
        tick();
    endtask

    initial begin
        abc_block = {32'h61626380, {14{32'h0}}, 32'h00000018};
        alt_block = {4{128'h00112233_44556677_8899AABB_CCDDEEFF}};
        exp_abc   = expand(abc_block);
        exp_alt   = expand(alt_block);
        test_reset();
        test_abc();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
